booth_mult_arbiter: RTL

//  Shares one signed Booth multiplier between N_REQ requesters. Arbitrates round-robin,

---
 rtl/booth_arb_pkg.sv | 21 ++
 rtl/booth_rr_arbiter.sv | 55 +++++
 rtl/booth_mult_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/booth_arb_pkg.sv
// Shared definitions for the Booth multiplier arbiter.
//  - arb_state_t : controller state encoding (IDLE, ISSUE, WAIT, RESP)
//  - DEF_N_REQ / DEF_W : default requester count and operand width
//  - sext_w() : sign-extends a DEF_W-bit operand to 2*DEF_W bits
package booth_arb_pkg;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  function automatic logic [2*DEF_W-1:0] sext_w(input logic [DEF_W-1:0] v);
    return {{DEF_W{v[DEF_W-1]}}, v};
  endfunction

endpackage

// File: rtl/booth_rr_arbiter.sv
// Combinational requester picker for the Booth multiplier arbiter.
// Default build: round-robin search starting at ptr and wrapping N_REQ-1 -> 0.
// Macro BOOTH_ARB_FIXED_PRIO_EN: fixed priority, lowest index wins, ptr ignored.
// Ports:
//  req        in   N_REQ  pending requests
//  ptr        in   ID_W   round-robin start index
//  grant      out  N_REQ  one-hot winner (all zero when no request)
//  grant_idx  out  ID_W   index of the winner
//  grant_any  out  1      at least one request pending
module booth_rr_arbiter
  import booth_arb_pkg::*;
#(
  parameter  int N_REQ = DEF_N_REQ,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx,
  output logic             grant_any
);

  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

`ifdef BOOTH_ARB_FIXED_PRIO_EN
  logic ptr_unused_s;
  assign ptr_unused_s = ^ptr;

  // Fixed priority: scanned from the top down so the lowest pending index is written last.
  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      grant_idx = req[ID_W'(k)] ? ID_W'(k) : grant_idx;
      grant_any = grant_any | req[ID_W'(k)];
    end
    grant = grant_any ? (ONE_HOT0 << grant_idx) : '0;
  end
`else
  // Round-robin: offsets scanned from farthest to nearest so offset 0 (ptr itself) wins ties.
  always_comb begin
    logic [ID_W-1:0] j;
    j         = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j         = ID_W'((int'(ptr) + k) % N_REQ);
      grant_idx = req[j] ? j : grant_idx;
      grant_any = grant_any | req[j];
    end
    grant = grant_any ? (ONE_HOT0 << grant_idx) : '0;
  end
`endif

endmodule

// File: rtl/booth_mult_arbiter.sv
// Shares one signed Booth multiplier between N_REQ requesters.
// Arbitrates, latches the winner's operands, runs the multiplier over a
// start/busy handshake and returns the product with a one-hot response pulse.
// Optional macro BOOTH_ARB_FIXED_PRIO_EN: fixed priority instead of round-robin
// (the round-robin pointer is then held at 0).
// Ports:
//  clock, reset_n     rising-edge clock, asynchronous active-low reset
//  req_valid/ready    per-requester handshake, ready is one-hot and only in IDLE
//  req_a, req_b       packed signed operands, requester i at [i*W +: W]
//  resp_valid         one-cycle one-hot pulse to the owner of resp_product
//  resp_product/id    captured product and its owner, held until the next capture
//  mul_start          one-cycle start pulse to the multiplier
//  mul_a, mul_b       operands to the multiplier, held from ISSUE until capture
//  mul_busy           multiplier busy (tie 0 for a combinational multiplier)
//  mul_product        multiplier result
//  busy               high whenever the controller is not idle
module booth_mult_arbiter
  import booth_arb_pkg::*;
#(
  parameter  int N_REQ = DEF_N_REQ,
  parameter  int W     = DEF_W,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic [N_REQ-1:0]   resp_valid,
  output logic [2*W-1:0]     resp_product,
  output logic [ID_W-1:0]    resp_id,
  output logic               mul_start,
  output logic [W-1:0]       mul_a,
  output logic [W-1:0]       mul_b,
  input  logic               mul_busy,
  input  logic [2*W-1:0]     mul_product,
  output logic               busy
);

  localparam logic [ID_W-1:0]  LAST_IDX = ID_W'(N_REQ - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

  arb_state_t       state_r;
  logic [ID_W-1:0]  rr_ptr_r;
  logic [ID_W-1:0]  owner_r;
  logic [N_REQ-1:0] grant_s;
  logic [ID_W-1:0]  grant_idx_s;
  logic             grant_any_s;
  logic [ID_W-1:0]  ptr_next_s;

  booth_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr_r),
    .grant     (grant_s),
    .grant_idx (grant_idx_s),
    .grant_any (grant_any_s)
  );

  // Ready is offered only while idle; gated by reset so all outputs read 0 during reset.
  assign req_ready = ((state_r == ST_IDLE) && reset_n) ? grant_s : '0;

`ifdef BOOTH_ARB_FIXED_PRIO_EN
  assign ptr_next_s = '0;
`else
  assign ptr_next_s = (grant_idx_s == LAST_IDX) ? '0 : (grant_idx_s + 1'b1);
`endif

  // Controller FSM with registered outputs: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      rr_ptr_r     <= '0;
      owner_r      <= '0;
      resp_valid   <= '0;
      resp_product <= '0;
      resp_id      <= '0;
      mul_start    <= 1'b0;
      mul_a        <= '0;
      mul_b        <= '0;
      busy         <= 1'b0;
    end else begin
      mul_start  <= 1'b0;
      resp_valid <= '0;
      case (state_r)
        ST_IDLE: begin
          if (grant_any_s) begin
            mul_a     <= req_a[grant_idx_s*W +: W];
            mul_b     <= req_b[grant_idx_s*W +: W];
            owner_r   <= grant_idx_s;
            rr_ptr_r  <= ptr_next_s;
            mul_start <= 1'b1;
            busy      <= 1'b1;
            state_r   <= ST_ISSUE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          // mul_busy is only looked at here; the cycle of the start pulse is never a capture cycle.
          if (!mul_busy) begin
            resp_product <= mul_product;
            resp_id      <= owner_r;
            resp_valid   <= ONE_HOT0 << owner_r;
            state_r      <= ST_RESP;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_RESP: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
